// File: rtl/spw_fifo_tx_param.sv
// SpaceWire transmit FIFO with registered first-word-fall-through output stage.
// Optional packet-gated presentation is enabled by defining SPW_FIFO_TX_PKT_MODE_EN.
module spw_fifo_tx_param #(
   parameter int unsigned DWIDTH   = 9,
   parameter int unsigned AWIDTH   = 6,
   parameter int unsigned AF_LEVEL = 56
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DWIDTH-1:0] data_in,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] data_out,
   output logic              write_tx,
   output logic              f_full,
   output logic              f_empty,
   output logic              f_almost_full,
   output logic              overflow,
   output logic [AWIDTH:0]   counter,
   output logic [AWIDTH:0]   pkt_count
);

   localparam int unsigned DEPTH = 2 ** AWIDTH;
   localparam int unsigned CW    = AWIDTH + 1;

   typedef enum logic {
      S_IDLE,
      S_VALID
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DWIDTH-1:0]   r_mem [DEPTH];
   logic [AWIDTH-1:0]   r_wr_ptr;
   logic [AWIDTH-1:0]   r_rd_ptr;
   logic [AWIDTH-1:0]   w_rd_addr;
   logic [CW-1:0]       r_counter;
   logic [DWIDTH-1:0]   r_dout;
   logic                r_overflow;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_load;
   logic                w_gate;

   // The head word stays in memory until popped, so the output register is part of DEPTH.
   assign w_pop  = rd_en & write_tx;
   assign w_push = wr_en & (~f_full | w_pop);
   assign w_drop = wr_en & f_full & ~w_pop;

   assign write_tx      = (r_state == S_VALID);
   assign data_out      = r_dout;
   assign counter       = r_counter;
   assign overflow      = r_overflow;
   assign f_full        = (r_counter == CW'(DEPTH));
   assign f_empty       = (r_counter == CW'(0));
   assign f_almost_full = (r_counter >= CW'(AF_LEVEL));

`ifdef SPW_FIFO_TX_PKT_MODE_EN
   logic [CW-1:0] r_pkt_count;
   logic          w_pkt_inc;
   logic          w_pkt_dec;

   assign w_pkt_inc = w_push & data_in[DWIDTH-1];
   assign w_pkt_dec = w_pop & r_dout[DWIDTH-1];
   // Full override keeps a packet longer than the FIFO from deadlocking.
   assign w_gate    = (r_pkt_count != CW'(0)) | f_full;
   assign pkt_count = r_pkt_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pkt_count <= '0;
      end else if (clear) begin
         r_pkt_count <= '0;
      end else begin
         case ({w_pkt_inc, w_pkt_dec})
            2'b10:   r_pkt_count <= r_pkt_count + CW'(1);
            2'b01:   r_pkt_count <= r_pkt_count - CW'(1);
            default: r_pkt_count <= r_pkt_count;
         endcase
      end
   end
`else
   assign w_gate    = 1'b1;
   assign pkt_count = '0;
`endif

   // Output stage state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output stage next state and head-load selection.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_rd_addr   = r_rd_ptr;
      case (r_state)
         S_IDLE: begin
            if ((r_counter != CW'(0)) && w_gate) begin
               w_state_nxt = S_VALID;
               w_load      = 1'b1;
            end
         end
         S_VALID: begin
            if (w_pop) begin
               if (r_counter > CW'(1)) begin
                  w_load    = 1'b1;
                  w_rd_addr = r_rd_ptr + AWIDTH'(1);
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_load      = 1'b0;
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clock) begin
      if (w_push && !clear) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_dout <= '0;
      end else if (w_load) begin
         r_dout <= r_mem[w_rd_addr];
      end
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_counter  <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_counter  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_counter <= r_counter + CW'(1);
            2'b01:   r_counter <= r_counter - CW'(1);
            default: r_counter <= r_counter;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule
